// File: rtl/ahb_burst_master_if.sv
// Command and AHB-Lite bus bundle for ahb_burst_master.
// master = the burst engine, slave = the bus/command environment.
interface ahb_burst_master_if;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_write;
  logic [31:0]  cmd_addr;
  logic [2:0]   cmd_size;
  logic         cmd_len4;
  logic [127:0] cmd_wdata;
  logic [127:0] rd_data;
  logic         done;
  logic         err;
  logic         HSEL;
  logic [31:0]  HADDR;
  logic         HWRITE;
  logic [1:0]   HTRANS;
  logic [2:0]   HSIZE;
  logic [2:0]   HBURST;
  logic [31:0]  HWDATA;
  logic         HREADY;
  logic [31:0]  HRDATA;
  logic [1:0]   HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size,
    input  cmd_len4, cmd_wdata,
    input  HREADY, HRDATA, HRESP,
    output cmd_ready, rd_data, done, err,
    output HSEL, HADDR, HWRITE, HTRANS, HSIZE,
    output HBURST, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size,
    output cmd_len4, cmd_wdata,
    output HREADY, HRDATA, HRESP,
    input  cmd_ready, rd_data, done, err,
    input  HSEL, HADDR, HWRITE, HTRANS, HSIZE,
    input  HBURST, HWDATA
  );
endinterface

// File: rtl/ahb_burst_master.sv
// AHB-Lite SINGLE/INCR4 burst master with pipelined address/data phases.
// Optional macro AHB_MST_TIMEOUT_EN adds an HREADY-low abort counter.
module ahb_burst_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic HCLK,
  input logic HRESETn,
  ahb_burst_master_if.master bus
);
  typedef enum logic [1:0] {
    S_IDLE, S_ADDR, S_DATA, S_ERR
  } state_t;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t state, state_d;
  logic         wr_q, len4_q, d_act;
  logic         done_q, err_q;
  logic [1:0]   size_q, a_idx, d_idx, d_lane;
  logic [1:0]   trans_q, sz_in;
  logic [31:0]  addr_q, hwdata_q, nxt_addr;
  logic [31:0]  beat_w, addr_al;
  logic [127:0] wdata_q, rdata_q;
  logic accept, a_go, d_go, fin, fin_err;
  logic last_a, resp_err, to_hit, cancel;

  function automatic logic [31:0] lane_wr(
    input logic [31:0] b,
    input logic [1:0]  s
  );
    unique case (1'b1)
      s == 2'd0: lane_wr = {4{b[7:0]}};
      s == 2'd1: lane_wr = {2{b[15:0]}};
      default:   lane_wr = b;
    endcase
  endfunction

  function automatic logic [31:0] lane_rd(
    input logic [31:0] d,
    input logic [1:0]  s,
    input logic [1:0]  a
  );
    unique case (1'b1)
      s == 2'd0: lane_rd = {24'd0, d[{a, 3'b000} +: 8]};
      s == 2'd1: lane_rd = {16'd0, a[1] ? d[31:16] : d[15:0]};
      default:   lane_rd = d;
    endcase
  endfunction

  assign sz_in = (bus.cmd_size > 3'd2) ? 2'd2
                                       : bus.cmd_size[1:0];
  assign addr_al = bus.cmd_addr
                 & ~((32'd1 << sz_in) - 32'd1);
  assign last_a   = !len4_q || (a_idx == 2'd3);
  assign resp_err = (bus.HRESP == 2'b01) && !bus.HREADY;
  assign nxt_addr = addr_q + (32'd1 << size_q);
  assign beat_w   = wdata_q[{a_idx, 5'b00000} +: 32];

`ifdef AHB_MST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic busy;

  assign busy   = (state == S_ADDR) || (state == S_DATA);
  assign to_hit = busy && !bus.HREADY
               && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      to_cnt <= '0;
    end else if (busy && !bus.HREADY && !to_hit) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    a_go    = 1'b0;
    d_go    = 1'b0;
    fin     = 1'b0;
    fin_err = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          accept  = 1'b1;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (to_hit) begin
          state_d = S_IDLE;
          fin     = 1'b1;
          fin_err = 1'b1;
        end else if (d_act && resp_err) begin
          state_d = S_ERR;
        end else if (bus.HREADY) begin
          a_go = 1'b1;
          d_go = d_act;
          if (last_a) state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (to_hit) begin
          state_d = S_IDLE;
          fin     = 1'b1;
          fin_err = 1'b1;
        end else if (resp_err) begin
          state_d = S_ERR;
        end else if (bus.HREADY) begin
          d_go    = 1'b1;
          fin     = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        if (bus.HREADY) begin
          fin     = 1'b1;
          fin_err = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_q     <= 1'b0;
      len4_q   <= 1'b0;
      size_q   <= 2'd0;
      wdata_q  <= '0;
      addr_q   <= '0;
      trans_q  <= T_IDLE;
      a_idx    <= 2'd0;
      d_idx    <= 2'd0;
      d_lane   <= 2'd0;
      d_act    <= 1'b0;
      hwdata_q <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= fin;
      err_q  <= fin_err;
      if (accept) begin
        wr_q    <= bus.cmd_write;
        len4_q  <= bus.cmd_len4;
        size_q  <= sz_in;
        wdata_q <= bus.cmd_wdata;
        addr_q  <= addr_al;
        trans_q <= T_NSEQ;
        a_idx   <= 2'd0;
        d_act   <= 1'b0;
        rdata_q <= '0;
      end
      if (a_go) begin
        d_act    <= 1'b1;
        d_idx    <= a_idx;
        d_lane   <= addr_q[1:0];
        hwdata_q <= lane_wr(beat_w, size_q);
        if (!last_a) begin
          a_idx  <= a_idx + 2'd1;
          addr_q <= nxt_addr;
          // a beat that opens a new 1KB region restarts the burst
          trans_q <= (nxt_addr[9:0] == 10'd0) ? T_NSEQ
                                              : T_SEQ;
        end
      end
      if (d_go && !wr_q) begin
        rdata_q[{d_idx, 5'b00000} +: 32] <=
          lane_rd(bus.HRDATA, size_q, d_lane);
      end
      if (fin) d_act <= 1'b0;
    end
  end

  // an ERROR wait state cancels the pending beat in the same cycle
  assign cancel = (d_act && resp_err) || to_hit;

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.HSEL      = (state != S_IDLE);
  assign bus.HTRANS    = (state == S_ADDR && !cancel)
                       ? trans_q : T_IDLE;
  assign bus.HADDR     = addr_q;
  assign bus.HWRITE    = wr_q;
  assign bus.HSIZE     = {1'b0, size_q};
  assign bus.HBURST    = len4_q ? 3'b011 : 3'b000;
  assign bus.HWDATA    = hwdata_q;
  assign bus.rd_data   = rdata_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_ahb_burst_master.sv
// Scoreboard bench for ahb_burst_master with a small AHB memory slave.
// Directed bursts push expected address/data/completion records.
module tb_ahb_burst_master;
  logic HCLK;
  logic HRESETn;

  ahb_burst_master_if bus();

  ahb_burst_master #(.TIMEOUT_CYCLES(16)) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .bus(bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [2:0]  burst;
  } aph_t;

  typedef struct packed {
    logic         err;
    logic         chk;
    logic [127:0] rd;
  } dn_t;

  aph_t        exp_a[$];
  logic [31:0] exp_w[$];
  dn_t         exp_d[$];

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int done_base = 0;

  task automatic chk(input string n, input logic [127:0] act,
                     input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, req);
    end
  endtask

  task automatic unexp(input string n);
    total++;
    bad++;
    $display("FAIL unexpected_%s: got event want none", n);
  endtask

  // simple zero-wait memory slave, HREADY/HRESP driven by stimulus
  logic [31:0] mem [0:511];
  logic        s_dp, s_wr;
  logic [31:0] s_addr;
  logic [2:0]  s_size;

  function automatic logic [31:0] bmask(input logic [2:0] s,
                                        input logic [1:0] a);
    case (s)
      3'd0:    bmask = 32'hFF << {a, 3'b000};
      3'd1:    bmask = a[1] ? 32'hFFFF0000 : 32'h0000FFFF;
      default: bmask = 32'hFFFFFFFF;
    endcase
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s_dp <= 1'b0;
    end else if (bus.HREADY) begin
      if (s_dp && s_wr && bus.HRESP == 2'b00)
        mem[s_addr[10:2]] <=
          (mem[s_addr[10:2]] & ~bmask(s_size, s_addr[1:0]))
          | (bus.HWDATA & bmask(s_size, s_addr[1:0]));
      s_dp   <= bus.HTRANS[1];
      s_addr <= bus.HADDR;
      s_wr   <= bus.HWRITE;
      s_size <= bus.HSIZE;
    end
  end

  assign bus.HRDATA = (s_dp && !s_wr) ? mem[s_addr[10:2]]
                                      : 32'h0;

  // monitor: pops expectations whenever the bus presents an event
  logic mon_dp = 1'b0;
  logic mon_wr = 1'b0;
  aph_t ma;
  dn_t  md;
  logic [31:0] mw;

  always @(negedge HCLK) begin
    if (!HRESETn) begin
      mon_dp = 1'b0;
    end else begin
      if (bus.done) begin
        done_cnt++;
        if (exp_d.size() == 0) unexp("done");
        else begin
          md = exp_d.pop_front();
          chk("done_err", bus.err, md.err);
          if (md.chk) chk("rd_data", bus.rd_data, md.rd);
        end
      end
      if (mon_dp && mon_wr && bus.HREADY
          && bus.HRESP == 2'b00) begin
        if (exp_w.size() == 0) unexp("hwdata");
        else begin
          mw = exp_w.pop_front();
          chk("hwdata", bus.HWDATA, mw);
        end
      end
      if (bus.HTRANS[1] && bus.HREADY) begin
        if (exp_a.size() == 0) unexp("addr_phase");
        else begin
          ma = exp_a.pop_front();
          chk("haddr", bus.HADDR, ma.addr);
          chk("htrans", bus.HTRANS, ma.trans);
          chk("hctl", {bus.HWRITE, bus.HSIZE, bus.HBURST},
              {ma.wr, ma.size, ma.burst});
        end
        mon_wr = bus.HWRITE;
      end
      if (bus.HREADY) mon_dp = bus.HTRANS[1];
    end
  end

  task automatic pa(input logic [31:0] a, input logic [1:0] t,
                    input logic w, input logic [2:0] s,
                    input logic [2:0] b);
    exp_a.push_back('{a, t, w, s, b});
  endtask

  task automatic pd(input logic e, input logic c,
                    input logic [127:0] r);
    exp_d.push_back('{e, c, r});
  endtask

  task automatic check_reset(input string t);
    chk({t, "_ready"}, bus.cmd_ready, 1'b1);
    chk({t, "_done"}, bus.done, 1'b0);
    chk({t, "_err"}, bus.err, 1'b0);
    chk({t, "_hsel"}, bus.HSEL, 1'b0);
    chk({t, "_htrans"}, bus.HTRANS, 2'b00);
    chk({t, "_haddr"}, bus.HADDR, 32'h0);
    chk({t, "_hwrite"}, bus.HWRITE, 1'b0);
    chk({t, "_hsize"}, bus.HSIZE, 3'd0);
    chk({t, "_hburst"}, bus.HBURST, 3'd0);
    chk({t, "_hwdata"}, bus.HWDATA, 32'h0);
    chk({t, "_rd_data"}, bus.rd_data, 128'h0);
  endtask

  task automatic issue(input logic w, input logic [31:0] a,
                       input logic [2:0] s, input logic l4,
                       input logic [127:0] wd);
    @(posedge HCLK);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_size  = s;
    bus.cmd_len4  = l4;
    bus.cmd_wdata = wd;
    chk("cmd_ready_idle", bus.cmd_ready, 1'b1);
    @(posedge HCLK);
    #1;
    bus.cmd_valid = 1'b0;
    done_base = done_cnt;
    chk("cmd_ready_busy", bus.cmd_ready, 1'b0);
  endtask

  task automatic wait_done(input string t);
    int n = 0;
    while (done_cnt == done_base && n < 60) begin
      @(posedge HCLK);
      n++;
    end
    chk({t, "_done_seen"}, done_cnt != done_base, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_size  = '0;
    bus.cmd_len4  = 1'b0;
    bus.cmd_wdata = '0;
    bus.HREADY    = 1'b1;
    bus.HRESP     = 2'b00;
    HRESETn = 1'b1;
    #1 HRESETn = 1'b0;
    #2 check_reset("rst");
    @(negedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // word INCR4 write at 0x00, plus latency and idle-after-last
    pa(32'h0, 2'b10, 1, 3'd2, 3'b011);
    pa(32'h4, 2'b11, 1, 3'd2, 3'b011);
    pa(32'h8, 2'b11, 1, 3'd2, 3'b011);
    pa(32'hC, 2'b11, 1, 3'd2, 3'b011);
    exp_w.push_back(32'h12345678);
    exp_w.push_back(32'h34567812);
    exp_w.push_back(32'h56781234);
    exp_w.push_back(32'h78123456);
    pd(0, 0, '0);
    issue(1, 32'h0, 3'd2, 1,
          {32'h78123456, 32'h56781234,
           32'h34567812, 32'h12345678});
    repeat (4) @(posedge HCLK);
    #1;
    chk("last_htrans_idle", bus.HTRANS, 2'b00);
    chk("last_hsel", bus.HSEL, 1'b1);
    @(posedge HCLK);
    #1;
    chk("done_6_cycles", bus.done, 1'b1);
    wait_done("w_incr4");

    // word INCR4 read back
    pa(32'h0, 2'b10, 0, 3'd2, 3'b011);
    pa(32'h4, 2'b11, 0, 3'd2, 3'b011);
    pa(32'h8, 2'b11, 0, 3'd2, 3'b011);
    pa(32'hC, 2'b11, 0, 3'd2, 3'b011);
    pd(0, 1, 128'h78123456_56781234_34567812_12345678);
    issue(0, 32'h0, 3'd2, 1, '0);
    wait_done("r_incr4");

    // SINGLE word read
    pa(32'h4, 2'b10, 0, 3'd2, 3'b000);
    pd(0, 1, {96'h0, 32'h34567812});
    issue(0, 32'h4, 3'd2, 0, '0);
    wait_done("r_single");

    // byte INCR4 write at 0x10
    pa(32'h10, 2'b10, 1, 3'd0, 3'b011);
    pa(32'h11, 2'b11, 1, 3'd0, 3'b011);
    pa(32'h12, 2'b11, 1, 3'd0, 3'b011);
    pa(32'h13, 2'b11, 1, 3'd0, 3'b011);
    exp_w.push_back(32'h78787878);
    exp_w.push_back(32'h12121212);
    exp_w.push_back(32'h34343434);
    exp_w.push_back(32'h56565656);
    pd(0, 0, '0);
    issue(1, 32'h10, 3'd0, 1,
          {32'h56, 32'h34, 32'h12, 32'h78});
    wait_done("wb_incr4");

    // byte INCR4 read back
    pa(32'h10, 2'b10, 0, 3'd0, 3'b011);
    pa(32'h11, 2'b11, 0, 3'd0, 3'b011);
    pa(32'h12, 2'b11, 0, 3'd0, 3'b011);
    pa(32'h13, 2'b11, 0, 3'd0, 3'b011);
    pd(0, 1, {32'h56, 32'h34, 32'h12, 32'h78});
    issue(0, 32'h10, 3'd0, 1, '0);
    wait_done("rb_incr4");

    // halfword INCR4 write with two wait states on beat 1
    pa(32'h20, 2'b10, 1, 3'd1, 3'b011);
    pa(32'h22, 2'b11, 1, 3'd1, 3'b011);
    pa(32'h24, 2'b11, 1, 3'd1, 3'b011);
    pa(32'h26, 2'b11, 1, 3'd1, 3'b011);
    exp_w.push_back(32'h11111111);
    exp_w.push_back(32'h22222222);
    exp_w.push_back(32'h33333333);
    exp_w.push_back(32'h44444444);
    pd(0, 0, '0);
    issue(1, 32'h20, 3'd1, 1,
          {32'h4444, 32'h3333, 32'h2222, 32'h1111});
    @(posedge HCLK);
    @(posedge HCLK);
    #1;
    bus.HREADY = 1'b0;
    chk("wait0_haddr", bus.HADDR, 32'h24);
    chk("wait0_hwdata", bus.HWDATA, 32'h22222222);
    @(posedge HCLK);
    #1;
    chk("wait1_haddr", bus.HADDR, 32'h24);
    chk("wait1_htrans", bus.HTRANS, 2'b11);
    chk("wait1_hwdata", bus.HWDATA, 32'h22222222);
    @(posedge HCLK);
    #1;
    bus.HREADY = 1'b1;
    wait_done("wh_incr4");

    pa(32'h20, 2'b10, 0, 3'd1, 3'b011);
    pa(32'h22, 2'b11, 0, 3'd1, 3'b011);
    pa(32'h24, 2'b11, 0, 3'd1, 3'b011);
    pa(32'h26, 2'b11, 0, 3'd1, 3'b011);
    pd(0, 1, {32'h4444, 32'h3333, 32'h2222, 32'h1111});
    issue(0, 32'h20, 3'd1, 1, '0);
    wait_done("rh_incr4");

    // oversize and misaligned: size 3 at 0x32 -> word at 0x30
    pa(32'h30, 2'b10, 1, 3'd2, 3'b000);
    exp_w.push_back(32'hCAFEF00D);
    pd(0, 0, '0);
    issue(1, 32'h32, 3'd3, 0, {96'h0, 32'hCAFEF00D});
    wait_done("w_clamp");

    pa(32'h33, 2'b10, 0, 3'd0, 3'b000);
    pd(0, 1, {96'h0, 32'h000000CA});
    issue(0, 32'h33, 3'd0, 0, '0);
    wait_done("r_lane3");

    // 1KB crossing then ERROR response on beat 1
    pa(32'h3F8, 2'b10, 1, 3'd2, 3'b011);
    pa(32'h3FC, 2'b11, 1, 3'd2, 3'b011);
    exp_w.push_back(32'hA0A0A0A0);
    pd(1, 0, '0);
    issue(1, 32'h3F8, 3'd2, 1,
          {32'hA3A3A3A3, 32'hA2A2A2A2,
           32'hA1A1A1A1, 32'hA0A0A0A0});
    @(posedge HCLK);
    @(posedge HCLK);
    #1;
    chk("kb_haddr", bus.HADDR, 32'h400);
    chk("kb_htrans_nseq", bus.HTRANS, 2'b10);
    bus.HRESP  = 2'b01;
    bus.HREADY = 1'b0;
    #1;
    chk("err_htrans_idle", bus.HTRANS, 2'b00);
    @(posedge HCLK);
    #1;
    bus.HREADY = 1'b1;
    @(posedge HCLK);
    #1;
    bus.HRESP = 2'b00;
    wait_done("err_burst");

    // reset in mid-burst: no completion afterwards
    pa(32'h40, 2'b10, 1, 3'd2, 3'b011);
    issue(1, 32'h40, 3'd2, 1, 128'h1);
    @(posedge HCLK);
    #3;
    HRESETn = 1'b0;
    #1;
    check_reset("mid_rst");
    #2;
    HRESETn = 1'b1;
    repeat (8) @(posedge HCLK);
    chk("no_done_after_rst", done_cnt, done_base);

`ifdef AHB_MST_TIMEOUT_EN
    pd(1, 0, '0);
    issue(0, 32'h0, 3'd2, 0, '0);
    bus.HREADY = 1'b0;
    repeat (15) @(posedge HCLK);
    #1;
    chk("to_not_yet", bus.done, 1'b0);
    @(posedge HCLK);
    #1;
    chk("to_done", bus.done, 1'b1);
    chk("to_ready", bus.cmd_ready, 1'b1);
    bus.HREADY = 1'b1;
    wait_done("timeout");
`endif

    repeat (2) @(posedge HCLK);
    chk("left_addr", exp_a.size(), 0);
    chk("left_wdata", exp_w.size(), 0);
    chk("left_done", exp_d.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
